// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point ALU blocks (fp_mul, fp_div_seq).
// Rounding-mode encodings, IEEE single-precision constants, the divider FSM
// state type, operand classes and the exception-flag bundle.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, SPECIAL, CALC, ROUND, DONE} div_state_t;

  // Subnormals classify as zero (flush-to-zero).
  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fp_cls_t;

  typedef struct packed {
    logic ovrf;
    logic udrf;
    logic zer;
    logic inf;
    logic nan;
    logic dvz;
  } fp_flags_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational rounder/packer shared by the FP ALU datapaths.
// Inputs : sign, biased signed exponent e, fraction mant (hidden bit dropped),
//          guard g, sticky s, rounding mode r_mode.
// Outputs: packed result fp_Z, exponent overflow ovrf, underflow udrf.
// Overflow saturates to signed inf; underflow flushes to signed zero.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  e,
  input  logic [FRC_W-1:0]         mant,
  input  logic                     g,
  input  logic                     s,
  input  logic [2:0]               r_mode,
  output logic [EXP_W+FRC_W:0]     fp_Z,
  output logic                     ovrf,
  output logic                     udrf
);

  localparam logic signed [EXP_W+1:0] E_TOP = (EXP_W+2)'((1 << EXP_W) - 1);

  logic                    inx, inc, cy;
  logic [FRC_W-1:0]        mant_r;
  logic signed [EXP_W+1:0] e_r;

  always_comb begin
    inx = g | s;
    case (r_mode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = inx & sign;
      RM_RUP:  inc = inx & ~sign;
      RM_RMM:  inc = g;
      default: inc = g & (s | mant[0]);
    endcase

    // A carry out of the fraction means the significand became 2.0.
    {cy, mant_r} = {1'b0, mant} + (FRC_W+1)'(inc);
    e_r = e + $signed({{(EXP_W+1){1'b0}}, cy});

    ovrf = (e_r >= E_TOP);
    udrf = e_r[EXP_W+1] | (e_r == '0);

    fp_Z = {sign, e_r[EXP_W-1:0], mant_r};
    if (ovrf)      fp_Z = {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
    else if (udrf) fp_Z = {sign, {(EXP_W+FRC_W){1'b0}}};
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider, fp_Z = fp_X / fp_Y.
// Radix-2 restoring loop, one quotient bit per cycle, behind start/done.
// Ports: clk, rst (sync, active high); start, fp_X, fp_Y, r_mode sampled on
// accept (busy=0); busy while in flight; done pulses one cycle; fp_Z and the
// flags ovrf/udrf/zer/inf/nan/dvz are held until the next done.
// Latency from the accept cycle: specials +2, normal operands +QBITS+2.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23,
  parameter int QBITS = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+FRC_W:0] fp_X,
  input  logic [EXP_W+FRC_W:0] fp_Y,
  input  logic [2:0]           r_mode,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+FRC_W:0] fp_Z,
  output logic                 ovrf,
  output logic                 udrf,
  output logic                 zer,
  output logic                 inf,
  output logic                 nan,
  output logic                 dvz
);

  localparam int W  = EXP_W + FRC_W + 1;
  localparam int MW = FRC_W + 1;
  localparam int CW = $clog2(QBITS);
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);

  function automatic fp_cls_t cls(input logic [W-1:0] v);
    if (v[W-2 -: EXP_W] == '0)      return CL_ZERO;
    if (&v[W-2 -: EXP_W])           return (v[FRC_W-1:0] == '0) ? CL_INF : CL_NAN;
    return CL_NORM;
  endfunction

  div_state_t       state, state_n;
  logic [W-1:0]     x_q, y_q;
  logic [2:0]       rm_q;
  logic [MW:0]      rem;
  logic [QBITS-1:0] q;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     z_q;
  fp_flags_t        flg_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (cls(fp_X) == CL_NORM && cls(fp_Y) == CL_NORM)
                                    ? CALC : SPECIAL;
      SPECIAL: state_n = DONE;
      CALC:    if (cnt == CW'(QBITS-1)) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ---------------- special-case result ----------------
  fp_cls_t    cx, cy;
  logic       sz;
  logic [W-1:0] spec_z;
  fp_flags_t  spec_f;

  always_comb begin
    cx     = cls(x_q);
    cy     = cls(y_q);
    sz     = x_q[W-1] ^ y_q[W-1];
    spec_f = '0;
    if (cx == CL_NAN || cy == CL_NAN || (cx == CL_INF && cy == CL_INF) ||
        (cx == CL_ZERO && cy == CL_ZERO)) begin
      spec_z     = QNAN;
      spec_f.nan = 1'b1;
    end else if (cx == CL_NORM && cy == CL_ZERO) begin
      spec_z     = {sz, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
      spec_f.inf = 1'b1;
      spec_f.dvz = 1'b1;
    end else if (cx == CL_INF) begin
      spec_z     = {sz, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
      spec_f.inf = 1'b1;
    end else begin
      spec_z     = {sz, {(W-1){1'b0}}};
      spec_f.zer = 1'b1;
    end
  end

  // ---------------- quotient step ----------------
  logic [MW:0] my, rem_nxt;
  logic        qbit;

  assign my      = {2'b01, y_q[FRC_W-1:0]};
  assign qbit    = (rem >= my);
  assign rem_nxt = qbit ? (rem - my) : rem;

  // ---------------- normalise + round ----------------
  logic                    top;
  logic signed [EXP_W+1:0] e_n;
  logic [FRC_W-1:0]        mant_n;
  logic                    g_n, s_n;
  logic [W-1:0]            rp_z;
  logic                    rp_ov, rp_ud;

  always_comb begin
    top = q[QBITS-1];
    e_n = $signed({2'b00, x_q[W-2 -: EXP_W]}) - $signed({2'b00, y_q[W-2 -: EXP_W]})
        + (top ? BIAS_S : BIAS_S - 1);
    if (top) begin
      mant_n = q[QBITS-2 -: FRC_W];
      g_n    = q[2];
      s_n    = (|q[1:0]) | (|rem);
    end else begin
      mant_n = q[QBITS-3 -: FRC_W];
      g_n    = q[1];
      s_n    = q[0] | (|rem);
    end
  end

  fp_round_pack #(.EXP_W(EXP_W), .FRC_W(FRC_W)) u_rp (
    .sign  (sz),
    .e     (e_n),
    .mant  (mant_n),
    .g     (g_n),
    .s     (s_n),
    .r_mode(rm_q),
    .fp_Z  (rp_z),
    .ovrf  (rp_ov),
    .udrf  (rp_ud)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      rm_q  <= '0;
      rem   <= '0;
      q     <= '0;
      cnt   <= '0;
      z_q   <= '0;
      flg_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q  <= fp_X;
          y_q  <= fp_Y;
          rm_q <= r_mode;
          rem  <= {2'b01, fp_X[FRC_W-1:0]};
          q    <= '0;
          cnt  <= '0;
        end
        CALC: begin
          // rem_nxt < mY < 2^MW, so the shift never loses a bit.
          rem <= {rem_nxt[MW-1:0], 1'b0};
          q   <= {q[QBITS-2:0], qbit};
          cnt <= cnt + 1'b1;
        end
        SPECIAL: begin
          z_q   <= spec_z;
          flg_q <= spec_f;
        end
        ROUND: begin
          z_q   <= rp_z;
          flg_q <= '{ovrf: rp_ov, udrf: rp_ud, zer: rp_ud, inf: rp_ov,
                     nan: 1'b0, dvz: 1'b0};
        end
        default: ;
      endcase
    end
  end

  assign fp_Z = z_q;
  assign ovrf = flg_q.ovrf;
  assign udrf = flg_q.udrf;
  assign zer  = flg_q.zer;
  assign inf  = flg_q.inf;
  assign nan  = flg_q.nan;
  assign dvz  = flg_q.dvz;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed table, handshake corner
// sequences (start while busy, start in DONE, mid-operation reset) and
// random operands checked against an integer-arithmetic reference model.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] fp_X = '0, fp_Y = '0;
  logic [2:0]  r_mode = '0;
  logic        busy, done, ovrf, udrf, zer, inf, nan, dvz;
  logic [31:0] fp_Z;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .fp_X(fp_X), .fp_Y(fp_Y),
    .r_mode(r_mode), .busy(busy), .done(done), .fp_Z(fp_Z),
    .ovrf(ovrf), .udrf(udrf), .zer(zer), .inf(inf), .nan(nan), .dvz(dvz)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // flags packed as {ovrf, udrf, zer, inf, nan, dvz}
  function automatic logic [5:0] flags_now();
    return {ovrf, udrf, zer, inf, nan, dvz};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE; returns result, flags and cycles from accept
  // to the done cycle (accept cycle = 0).
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        output logic [31:0] z, output logic [5:0] f, output int lat);
    int w;
    w = 0;
    while (busy && w < 100) begin tick(); w++; end
    fp_X = x; fp_Y = y; r_mode = rm; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin tick(); lat++; end
    z = fp_Z;
    f = flags_now();
  endtask

  // Reference: classify per IEEE rules (subnormals as zero), and for normal
  // operands get the correctly truncated 24-bit significand plus one extra
  // bit and an exact sticky from a single wide integer division.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                                output logic [31:0] z, output logic [5:0] f, output int lat);
    int cx, cy, e, sh;
    logic sz, g, s, up;
    longint unsigned mx, my, num, qq, rr, m;
    cx = (x[30:23] == 0) ? 0 : (x[30:23] == 8'hFF) ? ((x[22:0] == 0) ? 2 : 3) : 1;
    cy = (y[30:23] == 0) ? 0 : (y[30:23] == 8'hFF) ? ((y[22:0] == 0) ? 2 : 3) : 1;
    sz = x[31] ^ y[31];
    lat = 2;
    if (cx == 3 || cy == 3 || (cx == 2 && cy == 2) || (cx == 0 && cy == 0)) begin
      z = 32'h7FC00000; f = 6'b000010;
    end else if (cx == 1 && cy == 0) begin
      z = {sz, 8'hFF, 23'd0}; f = 6'b000101;
    end else if (cx == 2) begin
      z = {sz, 8'hFF, 23'd0}; f = 6'b000100;
    end else if (cy == 2 || cx == 0) begin
      z = {sz, 31'd0}; f = 6'b001000;
    end else begin
      lat = 29;
      mx = {40'd1, x[22:0]};
      my = {40'd1, y[22:0]};
      if (mx >= my) begin sh = 23; e = int'(x[30:23]) - int'(y[30:23]) + 127; end
      else          begin sh = 24; e = int'(x[30:23]) - int'(y[30:23]) + 126; end
      num = mx << (sh + 1);
      qq  = num / my;
      rr  = num % my;
      g   = qq[0];
      s   = (rr != 0);
      m   = qq >> 1;
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = (g | s) & sz;
        3'd3:    up = (g | s) & ~sz;
        3'd4:    up = g;
        default: up = g & (s | m[0]);
      endcase
      m = m + longint'(up);
      if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e++; end
      if (e >= 255)    begin z = {sz, 8'hFF, 23'd0}; f = 6'b100100; end
      else if (e <= 0) begin z = {sz, 31'd0};        f = 6'b011000; end
      else begin z = {sz, 8'(e), 23'(m)}; f = 6'b000000; end
    end
  endfunction

  typedef struct {
    logic [31:0] x, y;
    logic [2:0]  rm;
    logic [31:0] z;
    logic [5:0]  f;
    int          lat;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [31:0] z, ez;
    logic [5:0]  f, ef;
    int          lat, elat, ndone;

    tv.push_back('{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 6'b000000, 29});
    tv.push_back('{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 6'b000000, 29});
    tv.push_back('{32'h40000000, 32'hC0800000, 3'd0, 32'hBF000000, 6'b000000, 29});
    tv.push_back('{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 6'b000101, 2});
    tv.push_back('{32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 6'b000101, 2});
    tv.push_back('{32'h3F800000, 32'h00000001, 3'd0, 32'h7F800000, 6'b000101, 2});
    tv.push_back('{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 6'b000010, 2});
    tv.push_back('{32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 6'b000010, 2});
    tv.push_back('{32'hFFC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 6'b000010, 2});
    tv.push_back('{32'h7F800000, 32'h40000000, 3'd0, 32'h7F800000, 6'b000100, 2});
    tv.push_back('{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 6'b000100, 2});
    tv.push_back('{32'hC0000000, 32'h7F800000, 3'd0, 32'h80000000, 6'b001000, 2});
    tv.push_back('{32'h00000000, 32'h40A00000, 3'd0, 32'h00000000, 6'b001000, 2});
    tv.push_back('{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 6'b001000, 2});
    tv.push_back('{32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 6'b100100, 29});
    tv.push_back('{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 6'b011000, 29});

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", fp_Z, 32'd0);
    chk("rst_flags", 32'(flags_now()), 32'd0);
    rst = 1'b0;
    tick();

    // ---- directed table ----
    foreach (tv[i]) begin
      run_op(tv[i].x, tv[i].y, tv[i].rm, z, f, lat);
      chk($sformatf("tv%0d_z", i), z, tv[i].z);
      chk($sformatf("tv%0d_flags", i), 32'(f), 32'(tv[i].f));
      chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
    end

    // ---- start while busy is ignored ----
    tick();
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin fp_X = 32'h3F800000; fp_Y = 32'h0; start = 1'b1; end
      else start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    chk("busy_ign_z", fp_Z, 32'h40400000);
    chk("busy_ign_flags", 32'(flags_now()), 32'd0);
    chk("busy_ign_lat", lat, 29);

    // ---- start in the DONE cycle is ignored; result is held ----
    fp_X = 32'h3F800000; fp_Y = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_ign_busy", 32'(busy), 32'd0);
    tick();
    chk("done_ign_busy2", 32'(busy), 32'd0);
    chk("hold_z", fp_Z, 32'h40400000);

    // ---- reset mid-operation: leave nonzero flags first ----
    run_op(32'h3F800000, 32'h00000000, 3'd0, z, f, lat);
    tick();
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_z", fp_Z, 32'd0);
    chk("abort_flags", 32'(flags_now()), 32'd0);
    ndone = 0;
    repeat (35) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    run_op(32'h40C00000, 32'h40000000, 3'd0, z, f, lat);
    chk("after_abort_z", z, 32'h40400000);
    chk("after_abort_lat", lat, 29);

    // ---- random operands vs reference model ----
    for (int n = 0; n < 300; n++) begin
      logic [31:0] x, y;
      logic [2:0]  rm;
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 9) == 0) x[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 9) == 0) y[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 19) == 0) x[22:0] = '0;
      if ($urandom_range(0, 19) == 0) y[22:0] = '0;
      if ($urandom_range(0, 1) != 0) begin
        // Keep exponents close so most results are in range.
        x[30:23] = 8'($urandom_range(100, 160));
        y[30:23] = 8'($urandom_range(100, 160));
      end
      rm = 3'($urandom_range(0, 7));
      model(x, y, rm, ez, ef, elat);
      run_op(x, y, rm, z, f, lat);
      chk($sformatf("rnd%0d_z(%h/%h rm%0d)", n, x, y, rm), z, ez);
      chk($sformatf("rnd%0d_flags", n), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_lat", n), lat, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
